cordic_iter_controller: RTL and testbench

//  Iterative CORDIC engine controller. Sequences one shift-add iteration per clock over the x/y/z datapath.

---
 rtl/cordic_iter_controller_pkg.sv | 17 +
 rtl/cordic_iter_controller_if.sv | 31 +++
 rtl/cordic_iter_controller_stage.sv | 34 +++
 rtl/cordic_iter_controller.sv | 169 ++++++++++++++++
 tb/tb_cordic_iter_controller.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_iter_controller_pkg.sv
// Shared definitions for the iterative CORDIC controller: control register
// bit positions, FSM states and operating modes.
package cordic_iter_controller_pkg;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_MODE     = 1;
  localparam int unsigned CTRL_INT_EN   = 2;
  localparam int unsigned CTRL_BUSY     = 3;
  localparam int unsigned CTRL_DONE     = 4;
  localparam int unsigned CTRL_ERR      = 5;
  localparam int unsigned CTRL_ABORT    = 6;
  localparam int unsigned CTRL_ITER_LSB = 8;

  typedef enum logic [1:0] {IDLE, ITER, FINISH} cordic_state_t;
  typedef enum logic {ROTATE, VECTOR} cordic_mode_t;

endpackage

// File: rtl/cordic_iter_controller_if.sv
// Register-file side bundle of the CORDIC controller: operands, control
// register access, results and the interrupt line.
interface cordic_iter_controller_if #(
  parameter int unsigned p_WIDTH = 32
);

  logic [p_WIDTH-1:0] xInput;
  logic [p_WIDTH-1:0] yInput;
  logic [p_WIDTH-1:0] zInput;
  logic [p_WIDTH-1:0] controlRegisterInput;
  logic               controlRegisterWrite;
  logic [p_WIDTH-1:0] xResult;
  logic [p_WIDTH-1:0] yResult;
  logic [p_WIDTH-1:0] zResult;
  logic [p_WIDTH-1:0] controlRegisterOutput;
  logic [p_WIDTH-1:0] controlRegisterMask;
  logic               interrupt;

  modport master (
    output xInput, yInput, zInput, controlRegisterInput, controlRegisterWrite,
    input  xResult, yResult, zResult, controlRegisterOutput, controlRegisterMask,
    input  interrupt
  );

  modport slave (
    input  xInput, yInput, zInput, controlRegisterInput, controlRegisterWrite,
    output xResult, yResult, zResult, controlRegisterOutput, controlRegisterMask,
    output interrupt
  );

endinterface

// File: rtl/cordic_iter_controller_stage.sv
// One combinational CORDIC shift-add micro-rotation. Gain is not compensated;
// arithmetic wraps in two's complement.
module cordic_iter_controller_stage
  import cordic_iter_controller_pkg::*;
#(
  parameter int unsigned p_WIDTH      = 32,
  parameter int unsigned p_LOG2_WIDTH = $clog2(p_WIDTH)
) (
  input  logic [p_WIDTH-1:0]      x_i,
  input  logic [p_WIDTH-1:0]      y_i,
  input  logic [p_WIDTH-1:0]      z_i,
  input  logic [p_WIDTH-1:0]      angle_i,
  input  logic [p_LOG2_WIDTH-1:0] shift_i,
  input  cordic_mode_t            mode_i,
  output logic [p_WIDTH-1:0]      x_o,
  output logic [p_WIDTH-1:0]      y_o,
  output logic [p_WIDTH-1:0]      z_o
);

  logic signed [p_WIDTH-1:0] x_sh;
  logic signed [p_WIDTH-1:0] y_sh;
  logic                      d_pos;

  assign x_sh = $signed(x_i) >>> shift_i;
  assign y_sh = $signed(y_i) >>> shift_i;

  // Rotation drives z toward zero, vectoring drives y toward zero
  assign d_pos = (mode_i == VECTOR) ? y_i[p_WIDTH-1] : ~z_i[p_WIDTH-1];

  assign x_o = d_pos ? (x_i - y_sh)    : (x_i + y_sh);
  assign y_o = d_pos ? (y_i + x_sh)    : (y_i - x_sh);
  assign z_o = d_pos ? (z_i - angle_i) : (z_i + angle_i);

endmodule

// File: rtl/cordic_iter_controller.sv
// Iterative CORDIC controller: owns the control/status register, sequences
// one micro-rotation per clock and captures results on completion.
module cordic_iter_controller
  import cordic_iter_controller_pkg::*;
#(
  parameter int unsigned p_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  cordic_iter_controller_if.slave    bus,
  input  logic [p_WIDTH-1:0]         angle,
  output logic [$clog2(p_WIDTH)-1:0] lutAddress
);

  localparam int unsigned LW = $clog2(p_WIDTH);

  cordic_state_t      state_q;
  cordic_mode_t       mode_q;
  cordic_mode_t       run_mode_q;
  logic               int_en_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic [LW-1:0]      iter_q;
  logic [LW-1:0]      cnt_q;
  logic [LW-1:0]      last_q;
  logic [p_WIDTH-1:0] x_q, y_q, z_q;
  logic [p_WIDTH-1:0] x_d, y_d, z_d;
  logic [p_WIDTH-1:0] xr_q, yr_q, zr_q;

  logic [p_WIDTH-1:0] wdata_c;
  logic               start_c;
  logic               abort_c;
  logic               w1c_done_c;
  logic               w1c_err_c;
  logic [LW-1:0]      wr_iter_c;
  logic [LW-1:0]      wr_last_c;
  logic               unused_wdata_c;

  assign wdata_c    = bus.controlRegisterInput;
  assign start_c    = bus.controlRegisterWrite & wdata_c[CTRL_START];
  assign abort_c    = bus.controlRegisterWrite & wdata_c[CTRL_ABORT];
  assign w1c_done_c = bus.controlRegisterWrite & wdata_c[CTRL_DONE];
  assign w1c_err_c  = bus.controlRegisterWrite & wdata_c[CTRL_ERR];
  assign wr_iter_c  = wdata_c[CTRL_ITER_LSB +: LW];
  assign unused_wdata_c = ^{wdata_c[CTRL_BUSY], wdata_c[7],
                            wdata_c[p_WIDTH-1:CTRL_ITER_LSB+LW]};

  // Index of the final iteration: ITER=0 or ITER>width runs the full width
  assign wr_last_c = ((wr_iter_c == '0) || (32'(wr_iter_c) > p_WIDTH))
                     ? LW'(p_WIDTH - 1) : (wr_iter_c - LW'(1));

  // Single micro-rotation on the working registers
  cordic_iter_controller_stage #(
    .p_WIDTH      (p_WIDTH),
    .p_LOG2_WIDTH (LW)
  ) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .angle_i (angle),
    .shift_i (cnt_q),
    .mode_i  (run_mode_q),
    .x_o     (x_d),
    .y_o     (y_d),
    .z_o     (z_d)
  );

  // Control register, FSM, iteration counter and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= ROTATE;
      run_mode_q <= ROTATE;
      int_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      iter_q     <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      xr_q       <= '0;
      yr_q       <= '0;
      zr_q       <= '0;
    end else begin
      if (bus.controlRegisterWrite) begin
        mode_q   <= cordic_mode_t'(wdata_c[CTRL_MODE]);
        int_en_q <= wdata_c[CTRL_INT_EN];
        iter_q   <= wr_iter_c;
      end
      if (w1c_done_c) done_q <= 1'b0;
      if (w1c_err_c)  err_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_c) begin
            x_q        <= bus.xInput;
            y_q        <= bus.yInput;
            z_q        <= bus.zInput;
            run_mode_q <= cordic_mode_t'(wdata_c[CTRL_MODE]);
            last_q     <= wr_last_c;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            state_q    <= ITER;
          end
        end
        ITER: begin
          if (abort_c) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            if (start_c) err_q <= 1'b1;
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            if (cnt_q == last_q) begin
              cnt_q   <= '0;
              state_q <= FINISH;
            end else begin
              cnt_q <= cnt_q + LW'(1);
            end
          end
        end
        FINISH: begin
          if (abort_c) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (start_c) err_q <= 1'b1;
            xr_q    <= x_q;
            yr_q    <= y_q;
            zr_q    <= z_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Assemble the control/status image and the hardware-owned bit mask
  always_comb begin
    bus.controlRegisterOutput                       = '0;
    bus.controlRegisterOutput[CTRL_MODE]            = (mode_q == VECTOR);
    bus.controlRegisterOutput[CTRL_INT_EN]          = int_en_q;
    bus.controlRegisterOutput[CTRL_BUSY]            = busy_q;
    bus.controlRegisterOutput[CTRL_DONE]            = done_q;
    bus.controlRegisterOutput[CTRL_ERR]             = err_q;
    bus.controlRegisterOutput[CTRL_ITER_LSB +: LW]  = iter_q;
    bus.controlRegisterMask                         = '0;
    bus.controlRegisterMask[CTRL_BUSY]              = 1'b1;
    bus.controlRegisterMask[CTRL_DONE]              = 1'b1;
    bus.controlRegisterMask[CTRL_ERR]               = 1'b1;
  end

  assign bus.xResult   = xr_q;
  assign bus.yResult   = yr_q;
  assign bus.zResult   = zr_q;
  assign bus.interrupt = done_q & int_en_q;
  assign lutAddress    = (state_q == ITER) ? cnt_q : '0;

endmodule

// File: tb/tb_cordic_iter_controller.sv
// Bench for the iterative CORDIC controller with a real-valued arctangent LUT
// and a behavioural reference of the iteration rules.
module tb_cordic_iter_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] angle;
  logic [4:0]  lutAddress;
  logic signed [31:0] lut [32];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_x = '0, last_y = '0, last_z = '0;

  cordic_iter_controller_if #(.p_WIDTH(32)) bus();

  cordic_iter_controller #(.p_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .angle      (angle),
    .lutAddress (lutAddress)
  );

  always #5 clk = ~clk;
  assign angle = lut[lutAddress];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_ctrl(input bit start, input bit mode, input bit int_en,
                                          input bit abort, input logic [4:0] iter,
                                          input bit clr_done, input bit clr_err);
    logic [31:0] w;
    w = '0;
    w[0] = start; w[1] = mode; w[2] = int_en; w[4] = clr_done;
    w[5] = clr_err; w[6] = abort; w[12:8] = iter;
    return w;
  endfunction

  // One-cycle control register write; returns one cycle later
  task automatic bus_write(input logic [31:0] data);
    bus.controlRegisterInput = data;
    bus.controlRegisterWrite = 1'b1;
    tick();
    bus.controlRegisterWrite = 1'b0;
    bus.controlRegisterInput = '0;
  endtask

  // Polls DONE from cycle start_cyc; cyc = cycle DONE seen, -1 on timeout
  task automatic wait_done(input int start_cyc, input int budget, output int cyc);
    cyc = start_cyc;
    while (bus.controlRegisterOutput[4] !== 1'b1 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (bus.controlRegisterOutput[4] !== 1'b1) cyc = -1;
  endtask

  // Reference: apply the d = +/-1 micro-rotation rule n times
  task automatic model_run(input logic [31:0] xi, input logic [31:0] yi, input logic [31:0] zi,
                           input bit vec, input int iter,
                           output logic [31:0] xo, output logic [31:0] yo, output logic [31:0] zo);
    logic signed [31:0] x, y, z, xs, ys;
    int n;
    bit dpos;
    n = (iter == 0 || iter > 32) ? 32 : iter;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < n; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      dpos = vec ? (y < 0) : (z >= 0);
      if (dpos) begin x = x - ys; y = y + xs; z = z - lut[i]; end
      else      begin x = x + ys; y = y - xs; z = z + lut[i]; end
    end
    xo = x; yo = y; zo = z;
  endtask

  function automatic int absdiff(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (bus.controlRegisterOutput !== 32'h0) begin
      bad++; $display("FAIL reset_ctrl: got %h want 00000000", bus.controlRegisterOutput);
    end
    total++;
    if ({bus.xResult, bus.yResult, bus.zResult} !== 96'h0 || bus.interrupt !== 1'b0 || lutAddress !== 5'd0) begin
      bad++; $display("FAIL reset_outputs: got x=%h y=%h z=%h int=%b lut=%0d want all 0",
                      bus.xResult, bus.yResult, bus.zResult, bus.interrupt, lutAddress);
    end
    total++;
    if (bus.controlRegisterMask !== 32'h38) begin
      bad++; $display("FAIL mask: got %h want 00000038", bus.controlRegisterMask);
    end
  endtask

  task automatic test_rotation();
    logic [31:0] ex, ey, ez;
    int cyc;
    bus.xInput = 32'h26DD3B6A; bus.yInput = 32'h0; bus.zInput = 32'h3243F6A9;
    model_run(bus.xInput, bus.yInput, bus.zInput, 1'b0, 0, ex, ey, ez);
    bus_write(mk_ctrl(1, 0, 1, 0, 5'd0, 0, 0));
    wait_done(1, 100, cyc);
    total++;
    if (cyc !== 34) begin bad++; $display("FAIL rot_latency: got %0d want 34", cyc); end
    total++;
    if ({bus.xResult, bus.yResult, bus.zResult} !== {ex, ey, ez}) begin
      bad++; $display("FAIL rot_model: got %h %h %h want %h %h %h",
                      bus.xResult, bus.yResult, bus.zResult, ex, ey, ez);
    end
    total++;
    if (absdiff(bus.xResult, 32'h2D413CCD) > 8 || absdiff(bus.yResult, 32'h2D413CCD) > 8 ||
        absdiff(bus.zResult, 32'h0) > 8) begin
      bad++; $display("FAIL rot_accuracy: got %h %h %h want ~2d413ccd 2d413ccd 0",
                      bus.xResult, bus.yResult, bus.zResult);
    end
    total++;
    if (bus.interrupt !== 1'b1 || bus.controlRegisterOutput[3] !== 1'b0) begin
      bad++; $display("FAIL rot_irq: got int=%b busy=%b want 1 0", bus.interrupt, bus.controlRegisterOutput[3]);
    end
    last_x = ex; last_y = ey; last_z = ez;
  endtask

  task automatic test_vectoring();
    logic [31:0] ex, ey, ez, kx;
    real k;
    int cyc;
    k = 1.0;
    for (int i = 0; i < 32; i++) k = k * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    kx = 32'($rtoi($sqrt(0.5) * k * (2.0 ** 30) + 0.5));
    bus.xInput = 32'h20000000; bus.yInput = 32'h20000000; bus.zInput = 32'h0;
    model_run(bus.xInput, bus.yInput, bus.zInput, 1'b1, 0, ex, ey, ez);
    bus_write(mk_ctrl(1, 1, 0, 0, 5'd0, 0, 0));
    wait_done(1, 100, cyc);
    total++;
    if ({bus.xResult, bus.yResult, bus.zResult} !== {ex, ey, ez}) begin
      bad++; $display("FAIL vec_model: got %h %h %h want %h %h %h",
                      bus.xResult, bus.yResult, bus.zResult, ex, ey, ez);
    end
    total++;
    if (absdiff(bus.zResult, 32'h3243F6A9) > 8 || absdiff(bus.yResult, 32'h0) > 16 ||
        absdiff(bus.xResult, kx) > 16) begin
      bad++; $display("FAIL vec_accuracy: got %h %h %h want ~%h 0 3243f6a9",
                      bus.xResult, bus.yResult, bus.zResult, kx);
    end
    total++;
    if (bus.interrupt !== 1'b0 || cyc !== 34) begin
      bad++; $display("FAIL vec_irq_latency: got int=%b cyc=%0d want 0 34", bus.interrupt, cyc);
    end
    last_x = ex; last_y = ey; last_z = ez;
  endtask

  task automatic test_iter4();
    logic [31:0] ex, ey, ez;
    bus.xInput = $urandom; bus.yInput = $urandom; bus.zInput = $urandom;
    model_run(bus.xInput, bus.yInput, bus.zInput, 1'b0, 4, ex, ey, ez);
    bus_write(mk_ctrl(1, 0, 0, 0, 5'd4, 0, 0));
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (lutAddress !== 5'(c - 1) || bus.controlRegisterOutput[3] !== 1'b1) begin
        bad++; $display("FAIL iter4_lut c%0d: got lut=%0d busy=%b want %0d 1",
                        c, lutAddress, bus.controlRegisterOutput[3], c - 1);
      end
      tick();
    end
    total++;
    if (lutAddress !== 5'd0 || bus.controlRegisterOutput[4] !== 1'b0) begin
      bad++; $display("FAIL iter4_c5: got lut=%0d done=%b want 0 0", lutAddress, bus.controlRegisterOutput[4]);
    end
    tick();
    total++;
    if (bus.controlRegisterOutput[4] !== 1'b1 || {bus.xResult, bus.yResult, bus.zResult} !== {ex, ey, ez}) begin
      bad++; $display("FAIL iter4_done: got done=%b %h %h %h want 1 %h %h %h", bus.controlRegisterOutput[4],
                      bus.xResult, bus.yResult, bus.zResult, ex, ey, ez);
    end
    last_x = ex; last_y = ey; last_z = ez;
  endtask

  task automatic test_start_busy();
    logic [31:0] ex, ey, ez;
    int cyc;
    bus.xInput = $urandom; bus.yInput = $urandom; bus.zInput = $urandom;
    model_run(bus.xInput, bus.yInput, bus.zInput, 1'b1, 8, ex, ey, ez);
    bus_write(mk_ctrl(1, 1, 0, 0, 5'd8, 0, 0));
    tick(); tick();
    bus.xInput = $urandom; bus.yInput = $urandom; bus.zInput = $urandom;
    bus_write(mk_ctrl(1, 0, 0, 0, 5'd3, 0, 0));
    total++;
    if (bus.controlRegisterOutput[5] !== 1'b1 || bus.controlRegisterOutput[3] !== 1'b1) begin
      bad++; $display("FAIL busy_start_err: got err=%b busy=%b want 1 1",
                      bus.controlRegisterOutput[5], bus.controlRegisterOutput[3]);
    end
    wait_done(4, 100, cyc);
    total++;
    if (cyc !== 10 || {bus.xResult, bus.yResult, bus.zResult} !== {ex, ey, ez}) begin
      bad++; $display("FAIL busy_start_result: got cyc=%0d %h %h %h want 10 %h %h %h", cyc,
                      bus.xResult, bus.yResult, bus.zResult, ex, ey, ez);
    end
    bus_write(mk_ctrl(0, 0, 0, 0, 5'd0, 0, 1));
    total++;
    if (bus.controlRegisterOutput[5] !== 1'b0 || bus.controlRegisterOutput[4] !== 1'b1) begin
      bad++; $display("FAIL err_w1c: got err=%b done=%b want 0 1",
                      bus.controlRegisterOutput[5], bus.controlRegisterOutput[4]);
    end
    last_x = ex; last_y = ey; last_z = ez;
  endtask

  task automatic test_abort();
    bus.xInput = $urandom; bus.yInput = $urandom; bus.zInput = $urandom;
    bus_write(mk_ctrl(1, 0, 1, 0, 5'd0, 0, 0));
    for (int c = 1; c < 10; c++) tick();
    bus_write(mk_ctrl(0, 0, 1, 1, 5'd0, 0, 0));
    total++;
    if (bus.controlRegisterOutput[3] !== 1'b0 || bus.controlRegisterOutput[4] !== 1'b0 ||
        bus.interrupt !== 1'b0 || lutAddress !== 5'd0) begin
      bad++; $display("FAIL abort_state: got busy=%b done=%b int=%b lut=%0d want 0 0 0 0",
                      bus.controlRegisterOutput[3], bus.controlRegisterOutput[4], bus.interrupt, lutAddress);
    end
    for (int c = 0; c < 40; c++) tick();
    total++;
    if (bus.controlRegisterOutput[4] !== 1'b0 || {bus.xResult, bus.yResult, bus.zResult} !== {last_x, last_y, last_z}) begin
      bad++; $display("FAIL abort_results: got done=%b %h %h %h want 0 %h %h %h", bus.controlRegisterOutput[4],
                      bus.xResult, bus.yResult, bus.zResult, last_x, last_y, last_z);
    end
    bus_write(mk_ctrl(1, 1, 1, 0, 5'd0, 0, 0));
    for (int c = 1; c < 15; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (bus.controlRegisterOutput !== 32'h0 || {bus.xResult, bus.yResult, bus.zResult} !== 96'h0 ||
        bus.interrupt !== 1'b0 || lutAddress !== 5'd0) begin
      bad++; $display("FAIL midop_reset: got ctrl=%h x=%h int=%b lut=%0d want all 0",
                      bus.controlRegisterOutput, bus.xResult, bus.interrupt, lutAddress);
    end
    last_x = '0; last_y = '0; last_z = '0;
  endtask

  task automatic test_done_w1c();
    bus.xInput = $urandom; bus.yInput = $urandom; bus.zInput = $urandom;
    bus_write(mk_ctrl(1, 0, 1, 0, 5'd4, 0, 0));
    for (int c = 1; c < 5; c++) tick();
    bus_write(mk_ctrl(0, 0, 1, 0, 5'd4, 1, 0));
    total++;
    if (bus.controlRegisterOutput[4] !== 1'b1 || bus.interrupt !== 1'b1) begin
      bad++; $display("FAIL done_set_wins: got done=%b int=%b want 1 1",
                      bus.controlRegisterOutput[4], bus.interrupt);
    end
    bus_write(mk_ctrl(0, 0, 0, 0, 5'd4, 0, 0));
    total++;
    if (bus.interrupt !== 1'b0 || bus.controlRegisterOutput[4] !== 1'b1) begin
      bad++; $display("FAIL int_en_off: got int=%b done=%b want 0 1", bus.interrupt, bus.controlRegisterOutput[4]);
    end
    bus_write(mk_ctrl(0, 1, 1, 0, 5'd4, 0, 0));
    total++;
    if (bus.interrupt !== 1'b1 || bus.controlRegisterOutput[12:0] !== 13'h0416) begin
      bad++; $display("FAIL int_en_on: got int=%b ctrl=%h want 1 0416", bus.interrupt, bus.controlRegisterOutput[12:0]);
    end
    bus_write(mk_ctrl(0, 0, 1, 0, 5'd4, 1, 0));
    total++;
    if (bus.controlRegisterOutput[4] !== 1'b0 || bus.interrupt !== 1'b0) begin
      bad++; $display("FAIL done_w1c: got done=%b int=%b want 0 0", bus.controlRegisterOutput[4], bus.interrupt);
    end
  endtask

  // Randomized operations issued back to back, each START on the DONE cycle
  task automatic test_back_to_back();
    logic [31:0] ex, ey, ez;
    logic [4:0]  it;
    bit          md;
    int          cyc, n;
    for (int k = 0; k < 24; k++) begin
      it = (k == 0) ? 5'd1 : (k == 1) ? 5'd31 : (k == 2) ? 5'd0 : 5'($urandom_range(0, 31));
      md = 1'($urandom);
      n  = (it == 0) ? 32 : int'(it);
      bus.xInput = $urandom; bus.yInput = $urandom; bus.zInput = $urandom;
      model_run(bus.xInput, bus.yInput, bus.zInput, md, int'(it), ex, ey, ez);
      bus_write(mk_ctrl(1, md, 1'($urandom), 0, it, 0, 0));
      wait_done(1, 100, cyc);
      total++;
      if (cyc !== n + 2) begin
        bad++; $display("FAIL b2b_latency op%0d: got %0d want %0d", k, cyc, n + 2);
      end
      total++;
      if ({bus.xResult, bus.yResult, bus.zResult} !== {ex, ey, ez}) begin
        bad++; $display("FAIL b2b_result op%0d mode=%0d iter=%0d: got %h %h %h want %h %h %h", k, md, it,
                        bus.xResult, bus.yResult, bus.zResult, ex, ey, ez);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut[i] = 32'($rtoi($atan(2.0 ** (-1.0 * i)) * (2.0 ** 30) + 0.5));
    bus.xInput = '0; bus.yInput = '0; bus.zInput = '0;
    bus.controlRegisterInput = '0;
    bus.controlRegisterWrite = 1'b0;
    test_reset();
    test_rotation();
    test_vectoring();
    test_iter4();
    test_start_busy();
    test_abort();
    test_done_w1c();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
